md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Multiply/divide unit in the Execute stage. Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
//   Models the multi-cycle latency with a countdown and holds the architectural HI/LO registers.
//   Provides mfhi/mflo read data, which the E stage muxes into ALUOut before the E->M pipeline register.
//   The hazard unit stalls D on any md instruction while (md_start | md_busy).
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (and madd family when enabled); range 1..15
//   DIV_CYCLES   10  busy cycles for div/divu; range 1..15
// PORTS
//   clk       in   1   single clock; all state updates on posedge
//   rst       in   1   asynchronous, active-high reset
//   md_start  in   1   E-stage instruction is an md op this cycle (qualified by md_op)
//   md_op     in   4   operation code (mdu_pkg encodings)
//   md_a      in   32  rs value (forwarded)
//   md_b      in   32  rt value (forwarded)
//   md_rd_hi  in   1   1: md_rdata = HI, 0: md_rdata = LO (mfhi/mflo)
//   md_busy   out  1   registered; high while a mult/div is in flight
//   md_rdata  out  32  combinational read of architectural HI or LO
//   hi_out    out  32  architectural HI (debug/trace)
//   lo_out    out  32  architectural LO (debug/trace)
// BEHAVIOUR
//   - Reset (async): HI=0, LO=0, pending_hi/lo=0, count=0, md_busy=0; md_rdata=0 after reset.
//   - Accept: md_start & !md_busy & op in {MULT,MULTU,DIV,DIVU}.
//     Result computed combinationally from md_a/md_b and latched into pending_hi/lo.
//     count <= N (MULT_CYCLES or DIV_CYCLES); md_busy <= 1 from the next cycle.
//   - Each busy cycle: count <= count-1. When count==1: HI<=pending_hi, LO<=pending_lo, count<=0, md_busy<=0.
//     Net result: HI/LO become visible exactly N cycles after the accept edge.
//   - MTHI/MTLO: accepted when !md_busy; HI<=md_a or LO<=md_a at the next edge. md_busy stays 0.
//   - md_start while md_busy: ignored; no state change. The hazard unit guarantees this never happens.
//     The bench checks it with an assertion.
//   - md_rdata always reflects architectural HI/LO, never pending values.
//     mfhi/mflo are stalled by the hazard unit while busy.
//   - MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
//   - DIV: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
//     0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU: unsigned.
//   - Divide by zero (md_b==0): busy sequence runs normally; HI/LO left unchanged at completion.
//   - md_op NONE or unknown with md_start: no effect.
//   - Reset mid-operation: in-flight op is discarded; HI/LO return to 0 immediately.
// CONFIGURATION
//   MDU_MADD_EN defined: adds MADD/MADDU/MSUB/MSUBU.
//     {HI,LO} <= {HI,LO} +/- product (signed/unsigned), with MULT_CYCLES latency.
//     The accumulate base is HI/LO sampled at the accept edge.
//   MDU_MADD_EN undefined: those codes are treated as unknown (no effect). No accumulate adder is built.
// STRUCTURE
//   mdu_pkg: md_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6,
//     MADD=7, MADDU=8, MSUB=9, MSUBU=10) and default cycle constants.
//   Sub-module md_arith: purely combinational op/a/b(/hi,lo) -> {res_hi,res_lo,res_valid}.
//     res_valid=0 on divide by zero.
//   md_unit holds the countdown, busy flag, pending regs and HI/LO.
// TESTING
//   1 mult a=0xFFFFFFFE (-2), b=3 -> busy cycles 1..5 after accept; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2 divu a=7, b=2 -> busy for 10 cycles; then LO=3, HI=1. div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   3 div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. div by 0 -> HI/LO unchanged, busy still 10 cycles.
//   4 mthi 0x1234 then mtlo 0x5678 back-to-back -> HI=0x1234, LO=0x5678; md_busy never asserts;
//     md_rdata follows md_rd_hi next cycle.
//   5 rst asserted at cycle 3 of a div -> md_busy=0, HI=LO=0 at once; next mult accepted normally.
//   6 (MDU_MADD_EN) HI:LO=0:5, maddu a=2, b=3 -> LO=11 after 5 cycles; msub a=1, b=1 -> LO=10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared md_op encodings and default latencies for the multiply/divide unit.
// MADD-family codes exist always; md_arith only implements them under MDU_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: op/a/b -> {res_hi,res_lo,res_valid}; res_valid=0 on divide by zero.
// MDU_MADD_EN adds hi/lo accumulate inputs and MADD/MADDU/MSUB/MSUBU; otherwise those codes produce nothing.
module md_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic [63:0] prod_u, prod_s;
  logic [31:0] b_safe, a_mag, b_mag, bm_safe;
  logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

  assign prod_u = {32'b0, a} * {32'b0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Divisors are forced non-zero so the dividers never see zero; res_valid masks the result.
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  assign uq      = a / b_safe;
  assign ur      = a % b_safe;

  // Signed divide on magnitudes; 0x80000000 magnitude is exact in 32 unsigned bits.
  assign a_mag   = a[31] ? -a : a;
  assign b_mag   = b[31] ? -b : b;
  assign bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign sq_mag  = a_mag / bm_safe;
  assign sr_mag  = a_mag % bm_safe;
  assign sq      = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
  assign sr      = a[31] ? -sr_mag : sr_mag;

  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_valid = 1'b0;
    case (op)
      MD_MULT:  begin {res_hi, res_lo} = prod_s; res_valid = 1'b1; end
      MD_MULTU: begin {res_hi, res_lo} = prod_u; res_valid = 1'b1; end
      MD_DIV:   begin res_hi = sr; res_lo = sq; res_valid = (b != 32'd0); end
      MD_DIVU:  begin res_hi = ur; res_lo = uq; res_valid = (b != 32'd0); end
`ifdef MDU_MADD_EN
      MD_MADD:  begin {res_hi, res_lo} = {hi, lo} + prod_s; res_valid = 1'b1; end
      MD_MADDU: begin {res_hi, res_lo} = {hi, lo} + prod_u; res_valid = 1'b1; end
      MD_MSUB:  begin {res_hi, res_lo} = {hi, lo} - prod_s; res_valid = 1'b1; end
      MD_MSUBU: begin {res_hi, res_lo} = {hi, lo} - prod_u; res_valid = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: countdown latency model plus architectural HI/LO registers.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops with MULT_CYCLES latency.
module md_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_rd_hi,
  output logic        md_busy,
  output logic [31:0] md_rdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic        pend_vld;
  logic [3:0]  count;
  logic [31:0] res_hi, res_lo;
  logic        res_valid;
  logic        is_mul, is_div;

  md_arith u_arith (
    .op        (md_op),
    .a         (md_a),
    .b         (md_b),
`ifdef MDU_MADD_EN
    .hi        (hi),
    .lo        (lo),
`endif
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul = 1'b1;
`endif
      MD_DIV, MD_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_vld <= 1'b0;
      count    <= '0;
      md_busy  <= 1'b0;
    end else if (md_busy) begin
      // Starts during busy are dropped here; the hazard unit should never issue them.
      count <= count - 4'd1;
      if (count == 4'd1) begin
        md_busy <= 1'b0;
        if (pend_vld) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end else if (md_start) begin
      if (is_mul || is_div) begin
        pend_hi  <= res_hi;
        pend_lo  <= res_lo;
        pend_vld <= res_valid;
        count    <= is_div ? DIV_N : MULT_N;
        md_busy  <= 1'b1;
      end else if (md_op == MD_MTHI) begin
        hi <= md_a;
      end else if (md_op == MD_MTLO) begin
        lo <= md_a;
      end
    end
  end

  assign md_rdata = md_rd_hi ? hi : lo;
  assign hi_out   = hi;
  assign lo_out   = lo;

endmodule
